// File: rtl/intersection_ctrl.sv
// Round-robin intersection controller: green/yellow/all-red per group, demand skip, green rest, night flash.
// Moore outputs one cycle after the deciding edge; no handshake, inputs are level-sampled every cycle.
module intersection_ctrl #(
    parameter int N_DIR     = 2,
    parameter int G_CYC     = 8,
    parameter int Y_CYC     = 3,
    parameter int CLR_CYC   = 2,
    parameter int FLASH_CYC = 4,
    parameter int CNT_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_DIR-1:0]           req,
    input  logic                       night,
    output logic [N_DIR-1:0]           R,
    output logic [N_DIR-1:0]           G,
    output logic [N_DIR-1:0]           Y,
    output logic [$clog2(N_DIR)-1:0]   phase,
    output logic                       flash
);
    localparam int PH_W = $clog2(N_DIR);

    typedef enum logic [1:0] {S_CLR, S_GRN, S_YEL, S_FLASH} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [PH_W-1:0]   r_phase;
    logic              r_flash;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [PH_W-1:0]   w_phase_nxt;
    logic              w_flash_nxt;
    logic [CNT_W-1:0]  w_dur_m1;
    logic              w_end;
    logic [N_DIR-1:0]  w_onehot;
    logic              w_compete;
    logic [PH_W-1:0]   w_next_ph;
    logic [PH_W-1:0]   w_idx;
    logic              w_found;

    always_comb begin
        w_onehot          = '0;
        w_onehot[r_phase] = 1'b1;
    end

    // Demand from the group currently served never counts as competition.
    assign w_compete = |(req & ~w_onehot);

    always_comb begin
        w_next_ph = PH_W'((int'(r_phase) + 1) % N_DIR);
        w_found   = 1'b0;
        w_idx     = '0;
        for (int i = 1; i <= N_DIR; i++) begin
            w_idx = PH_W'((int'(r_phase) + i) % N_DIR);
            if (!w_found && req[w_idx]) begin
                w_found   = 1'b1;
                w_next_ph = w_idx;
            end
        end
    end

    always_comb begin
        case (r_state)
            S_CLR:   w_dur_m1 = CNT_W'(CLR_CYC - 1);
            S_GRN:   w_dur_m1 = CNT_W'(G_CYC - 1);
            S_YEL:   w_dur_m1 = CNT_W'(Y_CYC - 1);
            default: w_dur_m1 = CNT_W'(FLASH_CYC - 1);
        endcase
    end

    assign w_end = (r_cnt == w_dur_m1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_phase_nxt = r_phase;
        w_flash_nxt = r_flash;
        case (r_state)
            S_CLR: begin
                if (w_end) begin
                    w_cnt_nxt = '0;
                    if (night) begin
                        w_state_nxt = S_FLASH;
                        w_flash_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_GRN;
                        w_phase_nxt = w_next_ph;
                    end
                end
            end
            S_GRN: begin
                // Past minimum green the counter parks so the exit test stays armed.
                if (w_end) begin
                    w_cnt_nxt = r_cnt;
                    if (night || w_compete) begin
                        w_state_nxt = S_YEL;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            S_YEL: begin
                if (w_end) begin
                    w_state_nxt = S_CLR;
                    w_cnt_nxt   = '0;
                end
            end
            S_FLASH: begin
                if (!night) begin
                    w_state_nxt = S_CLR;
                    w_cnt_nxt   = '0;
                    w_flash_nxt = 1'b0;
                end else if (w_end) begin
                    w_cnt_nxt   = '0;
                    w_flash_nxt = ~r_flash;
                end
            end
            default: begin
                w_state_nxt = S_CLR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_CLR;
            r_cnt   <= '0;
            r_phase <= PH_W'(N_DIR - 1);
            r_flash <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_phase <= w_phase_nxt;
            r_flash <= w_flash_nxt;
        end
    end

    always_comb begin
        R = '1;
        G = '0;
        Y = '0;
        case (r_state)
            S_GRN: begin
                R = ~w_onehot;
                G = w_onehot;
            end
            S_YEL: begin
                R = ~w_onehot;
                Y = w_onehot;
            end
            S_FLASH: begin
                R = '0;
                Y = {N_DIR{r_flash}};
            end
            default: ;
        endcase
    end

    assign phase = r_phase;
    assign flash = (r_state == S_FLASH);

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed bench: a 2-group default instance and a 4-group short-timing instance.
module tb_intersection_ctrl;
    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [1:0] req_a;
    logic [3:0] req_b;
    logic       night_a, night_b;
    logic [1:0] ra, ga, ya;
    logic [3:0] rb, gb, yb;
    logic       ph_a, fl_a, fl_b;
    logic [1:0] ph_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    intersection_ctrl #(.N_DIR(2), .G_CYC(8), .Y_CYC(3), .CLR_CYC(2), .FLASH_CYC(4), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst_a), .req(req_a), .night(night_a),
        .R(ra), .G(ga), .Y(ya), .phase(ph_a), .flash(fl_a)
    );

    intersection_ctrl #(.N_DIR(4), .G_CYC(4), .Y_CYC(2), .CLR_CYC(1), .FLASH_CYC(4), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst_b), .req(req_b), .night(night_b),
        .R(rb), .G(gb), .Y(yb), .phase(ph_b), .flash(fl_b)
    );

    // Lamp patterns for u_a as {R,G,Y}
    localparam logic [5:0] A_CLR = 6'b11_00_00;
    localparam logic [5:0] A_G0  = 6'b10_01_00;
    localparam logic [5:0] A_G1  = 6'b01_10_00;
    localparam logic [5:0] A_Y0  = 6'b10_00_01;
    localparam logic [5:0] A_Y1  = 6'b01_00_10;
    localparam logic [5:0] A_FON = 6'b00_00_11;
    localparam logic [5:0] A_FOF = 6'b00_00_00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // kind 0 = all red, 1 = green of group k, 2 = yellow of group k; {R,G,Y}
    function automatic logic [11:0] lamps_b(input int kind, input int k);
        logic [3:0] oh;
        oh = 4'b0001 << k;
        if (kind == 1) return {~oh, oh, 4'h0};
        if (kind == 2) return {~oh, 4'h0, oh};
        return {4'hF, 4'h0, 4'h0};
    endfunction

    task automatic nx(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int ph;
        rst_a = 1'b1; rst_b = 1'b1;
        req_a = '0; req_b = '0;
        night_a = 1'b0; night_b = 1'b0;
        nx(2);
        chk("rst_lamps", {ra, ga, ya}, A_CLR);
        chk("rst_phase", ph_a, 1);
        chk("rst_flash", fl_a, 0);
        chk("rst_b_phase", ph_b, 3);

        rst_a = 1'b0;
        nx(1); chk("boot_clr", {ra, ga, ya}, A_CLR);
        nx(1); chk("boot_g0", {ra, ga, ya}, A_G0);
        chk("boot_ph0", ph_a, 0);

        nx(30); chk("rest_g0", {ra, ga, ya}, A_G0);
        req_a = 2'b10;
        nx(1); chk("demand_y0", {ra, ga, ya}, A_Y0);
        nx(2); chk("y0_end", {ra, ga, ya}, A_Y0);
        nx(1); chk("clr_a", {ra, ga, ya}, A_CLR);
        nx(1); chk("clr_b", {ra, ga, ya}, A_CLR);
        nx(1); chk("g1", {ra, ga, ya}, A_G1);
        chk("ph1", ph_a, 1);

        req_a = 2'b01;
        nx(7); chk("min_green_last", {ra, ga, ya}, A_G1);
        nx(1); chk("min_green_y1", {ra, ga, ya}, A_Y1);
        req_a = 2'b00;
        nx(2); chk("y1_end", {ra, ga, ya}, A_Y1);
        nx(1); chk("clr_c", {ra, ga, ya}, A_CLR);
        nx(2); chk("wrap_g0", {ra, ga, ya}, A_G0);
        chk("wrap_ph0", ph_a, 0);

        nx(1);
        night_a = 1'b1;
        nx(6); chk("night_g_full", {ra, ga, ya}, A_G0);
        nx(1); chk("night_y0", {ra, ga, ya}, A_Y0);
        nx(2);
        nx(1); chk("night_clr", {ra, ga, ya}, A_CLR);
        nx(1); chk("night_clr2", {ra, ga, ya}, A_CLR);
        nx(1); chk("flash_on", {ra, ga, ya}, A_FON);
        chk("flash_out", fl_a, 1);
        nx(3); chk("flash_on_end", {ra, ga, ya}, A_FON);
        nx(1); chk("flash_off", {ra, ga, ya}, A_FOF);
        chk("flash_out_off", fl_a, 1);
        nx(3); chk("flash_off_end", {ra, ga, ya}, A_FOF);
        nx(1); chk("flash_on2", {ra, ga, ya}, A_FON);

        night_a = 1'b0;
        nx(1); chk("day_clr", {ra, ga, ya}, A_CLR);
        chk("day_flash", fl_a, 0);
        nx(1); chk("day_clr2", {ra, ga, ya}, A_CLR);
        nx(1); chk("day_g1", {ra, ga, ya}, A_G1);
        chk("day_ph1", ph_a, 1);

        req_a = 2'b01;
        nx(7);
        nx(1); chk("pre_rst_y1", {ra, ga, ya}, A_Y1);
        nx(1);
        #2 rst_a = 1'b1;
        #1 chk("async_rst_lamps", {ra, ga, ya}, A_CLR);
        chk("async_rst_flash", fl_a, 0);
        req_a = 2'b00;
        nx(1);
        rst_a = 1'b0;
        nx(1); chk("post_rst_clr", {ra, ga, ya}, A_CLR);
        nx(1); chk("post_rst_g0", {ra, ga, ya}, A_G0);
        chk("post_rst_ph0", ph_a, 0);

        // Night pulse forces green exit but is gone by clearance end.
        nx(7);
        night_a = 1'b1;
        nx(1); chk("pulse_y0", {ra, ga, ya}, A_Y0);
        night_a = 1'b0;
        nx(2);
        nx(1); chk("pulse_clr", {ra, ga, ya}, A_CLR);
        nx(2); chk("pulse_g1", {ra, ga, ya}, A_G1);
        chk("pulse_noflash", fl_a, 0);

        req_b = 4'b1111;
        rst_b = 1'b0;
        nx(1);
        for (int p = 0; p < 8; p++) begin
            chk("full_g_start", {rb, gb, yb}, lamps_b(1, p % 4));
            chk("full_phase", ph_b, p % 4);
            nx(3); chk("full_g_end", {rb, gb, yb}, lamps_b(1, p % 4));
            nx(1); chk("full_y", {rb, gb, yb}, lamps_b(2, p % 4));
            nx(1);
            nx(1); chk("full_clr", {rb, gb, yb}, lamps_b(0, 0));
            nx(1);
        end

        req_b = 4'b1001;
        for (int q = 0; q < 4; q++) begin
            ph = (q % 2 == 0) ? 0 : 3;
            chk("skip_g", {rb, gb, yb}, lamps_b(1, ph));
            chk("skip_phase", ph_b, ph);
            nx(3); chk("skip_g_end", {rb, gb, yb}, lamps_b(1, ph));
            nx(1); chk("skip_y", {rb, gb, yb}, lamps_b(2, ph));
            nx(2); chk("skip_clr", {rb, gb, yb}, lamps_b(0, 0));
            nx(1);
        end
        chk("b_noflash", fl_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
